// File: rtl/ps2_kbd_pkg.sv
// Shared scan-code constants, parser states and the key event record for the PS/2 keyboard path.
// Combinational helpers only: no latency and no flow control live here.
package ps2_kbd_pkg;

  localparam logic [7:0] SC_BREAK      = 8'hF0;
  localparam logic [7:0] SC_EXT        = 8'hE0;
  localparam logic [7:0] SC_PAUSE      = 8'hE1;
  localparam logic [7:0] SC_FAKE_SHIFT = 8'h12;
  localparam logic [7:0] SC_ERR0       = 8'h00;
  localparam logic [7:0] SC_BAT_OK     = 8'hAA;
  localparam logic [7:0] SC_ACK        = 8'hFA;
  localparam logic [7:0] SC_RESEND     = 8'hFE;
  localparam logic [7:0] SC_ERR1       = 8'hFF;

  // Bytes following E1 that make up the rest of the Pause sequence.
  localparam logic [2:0] PAUSE_TAIL = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK,
    ST_SKIP
  } ps2_state_e;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } key_event_t;

  function automatic logic is_status(input logic [7:0] b);
    return (b == SC_ERR0) || (b == SC_BAT_OK) || (b == SC_ACK) ||
           (b == SC_RESEND) || (b == SC_ERR1);
  endfunction

endpackage

// File: rtl/key_event_fifo.sv
// First-word-fall-through FIFO of key events; a push shows at head_o the cycle after it is written.
// No internal backpressure: a push while full is ignored unless a pop happens in the same cycle.
module key_event_fifo
  import ps2_kbd_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  key_event_t               push_dat_i,
  input  logic                     pop_i,
  output key_event_t               head_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  key_event_t    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];

  always_comb begin
    pop_ok   = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a full FIFO can still accept.
    push_ok  = push_i && (!full_o || pop_ok);
    wr_ptr_d = push_ok ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop_ok ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= push_dat_i;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/ps2_key_event.sv
// PS/2 scan bytes -> make/break/repeat key events, queued in a FWFT FIFO; 2 cycles byte strobe to ev_valid.
// ev_ready pops the head; a full FIFO without a pop drops the new event and sets sticky overflow.
module ps2_key_event
  import ps2_kbd_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int HELD_KEYS   = 4,
  parameter int REPEAT_MODE = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         ev_valid,
  input  logic                         ev_ready,
  output logic [7:0]                   ev_code,
  output logic                         ev_ext,
  output logic                         ev_break,
  output logic                         ev_repeat,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic                         overflow,
  input  logic                         clr_overflow
);

  ps2_state_e state_q, state_d;
  logic [2:0] skip_q, skip_d;

  logic       emit;
  logic       em_ext;
  logic       em_brk;

  logic [HELD_KEYS-1:0] held_vld_q, held_vld_d;
  logic [8:0]           held_key_q [HELD_KEYS];
  logic [8:0]           held_key_d [HELD_KEYS];
  logic [HELD_KEYS-1:0] hit_vec;
  logic [HELD_KEYS-1:0] free_sel;
  logic                 free_found;

  logic       evt_vld_q, evt_vld_d;
  key_event_t evt_q, evt_d;

  logic       overflow_q, overflow_d;
  logic       fifo_full, fifo_empty, drop;
  key_event_t head;

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    emit    = 1'b0;
    em_ext  = 1'b0;
    em_brk  = 1'b0;
    if (byte_valid) begin
      unique case (state_q)
        ST_IDLE: begin
          if (byte_data == SC_BREAK) state_d = ST_BRK;
          else if (byte_data == SC_EXT) state_d = ST_EXT;
          else if (byte_data == SC_PAUSE) begin
            state_d = ST_SKIP;
            skip_d  = PAUSE_TAIL;
          end else if (!is_status(byte_data)) emit = 1'b1;
        end
        ST_EXT: begin
          if (byte_data == SC_BREAK) state_d = ST_EXT_BRK;
          else if (byte_data == SC_EXT) state_d = ST_EXT;
          else begin
            state_d = ST_IDLE;
            emit    = (byte_data != SC_FAKE_SHIFT);
            em_ext  = 1'b1;
          end
        end
        ST_BRK: begin
          state_d = ST_IDLE;
          emit    = 1'b1;
          em_brk  = 1'b1;
        end
        ST_EXT_BRK: begin
          state_d = ST_IDLE;
          emit    = (byte_data != SC_FAKE_SHIFT);
          em_ext  = 1'b1;
          em_brk  = 1'b1;
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q == 3'd1) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Lookup runs on the live byte against the registered table, so the table
  // written at edge k is already visible to the byte arriving at edge k+1.
  always_comb begin
    hit_vec    = '0;
    free_sel   = '0;
    free_found = 1'b0;
    for (int i = 0; i < HELD_KEYS; i++) begin
      hit_vec[i] = held_vld_q[i] && (held_key_q[i] == {em_ext, byte_data});
      if (!held_vld_q[i] && !free_found) begin
        free_sel[i] = 1'b1;
        free_found  = 1'b1;
      end
    end
  end

  always_comb begin
    held_vld_d = held_vld_q;
    held_key_d = held_key_q;
    evt_vld_d  = 1'b0;
    evt_d.code = byte_data;
    evt_d.ext  = em_ext;
    evt_d.brk  = em_brk;
    evt_d.rpt  = 1'b0;
    if (emit) begin
      if (em_brk) begin
        held_vld_d = held_vld_q & ~hit_vec;
        evt_vld_d  = 1'b1;
      end else if (|hit_vec) begin
        evt_d.rpt = 1'b1;
        evt_vld_d = (REPEAT_MODE != 0);
      end else begin
        evt_vld_d = 1'b1;
        for (int i = 0; i < HELD_KEYS; i++) begin
          if (free_sel[i]) begin
            held_vld_d[i] = 1'b1;
            held_key_d[i] = {em_ext, byte_data};
          end
        end
      end
    end
  end

  assign drop       = evt_vld_q && fifo_full && !ev_ready;
  assign overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      held_vld_q <= '0;
      for (int i = 0; i < HELD_KEYS; i++) held_key_q[i] <= '0;
      evt_vld_q  <= 1'b0;
      evt_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      held_vld_q <= held_vld_d;
      held_key_q <= held_key_d;
      evt_vld_q  <= evt_vld_d;
      evt_q      <= evt_d;
      overflow_q <= overflow_d;
    end
  end

  key_event_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_i     (evt_vld_q),
    .push_dat_i (evt_q),
    .pop_i      (ev_ready),
    .head_o     (head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty),
    .count_o    (fifo_count)
  );

  assign ev_valid  = !fifo_empty;
  assign ev_code   = head.code;
  assign ev_ext    = head.ext;
  assign ev_break  = head.brk;
  assign ev_repeat = head.rpt;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_ps2_key_event.sv
// Drives one byte stream into a drop-repeat and a queue-repeat instance and checks both against a queue model.
module tb_ps2_key_event;

  localparam int DEPTH = 8;
  localparam int HK    = 4;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rpt;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       ev_ready = 1'b0;
  logic       clr_overflow = 1'b0;

  logic       ev_valid   [2];
  logic [7:0] ev_code    [2];
  logic       ev_ext     [2];
  logic       ev_break   [2];
  logic       ev_repeat  [2];
  logic [3:0] fifo_count [2];
  logic       overflow   [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_event #(.FIFO_DEPTH(DEPTH), .HELD_KEYS(HK), .REPEAT_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid[0]), .ev_ready(ev_ready), .ev_code(ev_code[0]), .ev_ext(ev_ext[0]),
    .ev_break(ev_break[0]), .ev_repeat(ev_repeat[0]), .fifo_count(fifo_count[0]),
    .overflow(overflow[0]), .clr_overflow(clr_overflow));

  ps2_key_event #(.FIFO_DEPTH(DEPTH), .HELD_KEYS(HK), .REPEAT_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .ev_valid(ev_valid[1]), .ev_ready(ev_ready), .ev_code(ev_code[1]), .ev_ext(ev_ext[1]),
    .ev_break(ev_break[1]), .ev_repeat(ev_repeat[1]), .fifo_count(fifo_count[1]),
    .overflow(overflow[1]), .clr_overflow(clr_overflow));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: queued events, held-key sets, sticky overflow, one-cycle pending slot.
  ev_t        mq   [2][$];
  logic [8:0] held [2][$];
  ev_t        pend [2];
  bit         pend_vld [2];
  bit         movf [2];
  bit         p_ext, p_brk;
  int         p_skip;

  task automatic model_event(input logic [7:0] c, input bit x, input bit b);
    logic [8:0] key;
    int idx;
    key = {x, c};
    for (int d = 0; d < 2; d++) begin
      idx = -1;
      for (int i = 0; i < held[d].size(); i++) if (held[d][i] == key) idx = i;
      if (b) begin
        if (idx >= 0) held[d].delete(idx);
        pend[d] = '{code: c, ext: x, brk: 1'b1, rpt: 1'b0};
        pend_vld[d] = 1'b1;
      end else if (idx >= 0) begin
        pend[d] = '{code: c, ext: x, brk: 1'b0, rpt: 1'b1};
        pend_vld[d] = (d == 1);
      end else begin
        if (held[d].size() < HK) held[d].push_back(key);
        pend[d] = '{code: c, ext: x, brk: 1'b0, rpt: 1'b0};
        pend_vld[d] = 1'b1;
      end
    end
  endtask

  task automatic model_byte(input logic [7:0] b);
    if (p_skip > 0) p_skip--;
    else if (p_brk) begin
      if (!(p_ext && b == 8'h12)) model_event(b, p_ext, 1'b1);
      p_brk = 0; p_ext = 0;
    end else if (p_ext) begin
      if (b == 8'hF0) p_brk = 1;
      else if (b != 8'hE0) begin
        if (b != 8'h12) model_event(b, 1'b1, 1'b0);
        p_ext = 0;
      end
    end else begin
      if (b == 8'hF0) p_brk = 1;
      else if (b == 8'hE0) p_ext = 1;
      else if (b == 8'hE1) p_skip = 7;
      else if (!(b inside {8'h00, 8'hAA, 8'hFA, 8'hFE, 8'hFF})) model_event(b, 1'b0, 1'b0);
    end
  endtask

  bit m_full, m_pop;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int d = 0; d < 2; d++) begin
        mq[d].delete(); held[d].delete();
        pend_vld[d] = 0; movf[d] = 0;
      end
      p_ext = 0; p_brk = 0; p_skip = 0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        m_full = (mq[d].size() == DEPTH);
        m_pop  = ev_ready && (mq[d].size() > 0);
        if (m_pop) void'(mq[d].pop_front());
        if (pend_vld[d] && m_full && !m_pop) movf[d] = 1;
        else if (clr_overflow) movf[d] = 0;
        if (pend_vld[d] && (!m_full || m_pop)) mq[d].push_back(pend[d]);
        pend_vld[d] = 0;
      end
      if (byte_valid) model_byte(byte_data);
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("ev_valid%0d", d), 32'(ev_valid[d]), 32'(mq[d].size() != 0));
        chk($sformatf("fifo_count%0d", d), 32'(fifo_count[d]), 32'(mq[d].size()));
        chk($sformatf("overflow%0d", d), 32'(overflow[d]), 32'(movf[d]));
        if (mq[d].size() != 0)
          chk($sformatf("head%0d", d), {21'd0, ev_code[d], ev_ext[d], ev_break[d], ev_repeat[d]},
              32'(mq[d][0]));
      end
    end
  end

  task automatic strobe(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    byte_valid = 1'b0;
    #2;
    for (int d = 0; d < 2; d++) begin
      chk("rst_valid", 32'(ev_valid[d]), 0);
      chk("rst_code", 32'(ev_code[d]), 0);
      chk("rst_flags", {29'd0, ev_ext[d], ev_break[d], ev_repeat[d]}, 0);
      chk("rst_count", 32'(fifo_count[d]), 0);
      chk("rst_ovf", 32'(overflow[d]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic drain();
    ev_ready = 1'b1;
    for (int i = 0; i < 30 && (ev_valid[0] || ev_valid[1]); i++) @(negedge clk);
    ev_ready = 1'b0;
    chk("drain0", 32'(fifo_count[0]), 0);
    chk("drain1", 32'(fifo_count[1]), 0);
  endtask

  logic [7:0] pool [16] = '{8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h75, 8'h7C, 8'h14,
                            8'hF0, 8'hF0, 8'hE0, 8'hE0, 8'hE1, 8'h12, 8'hAA, 8'hFA};

  initial begin
    idle(2);
    do_reset();

    // Make/break of 1C, including first-event latency.
    strobe(8'h1C);
    chk("lat_edge_k", 32'(ev_valid[0]), 0);
    idle(1);
    chk("lat_edge_k1", 32'(ev_valid[0]), 1);
    chk("first_head", {21'd0, ev_code[0], ev_ext[0], ev_break[0], ev_repeat[0]}, 32'h0E0);
    strobe(8'hF0); strobe(8'h1C);
    idle(2);
    chk("mb_count", 32'(fifo_count[0]), 2);
    chk("mb_model1", 32'(mq[0][1]), {21'd0, 8'h1C, 3'b010});
    drain();

    // Typematic repeats: dropped in dut0, tagged in dut1.
    strobe(8'h1C); strobe(8'h1C); strobe(8'h1C); strobe(8'hF0); strobe(8'h1C);
    idle(2);
    chk("rep_count0", 32'(fifo_count[0]), 2);
    chk("rep_count1", 32'(fifo_count[1]), 4);
    chk("rep_model1", {mq[1][0].rpt, mq[1][1].rpt, mq[1][2].rpt, mq[1][3].brk}, 4'b0111);
    drain();

    // Extended keys, fake shift, Pause.
    foreach (pool[i]) ; // keeps pool referenced before the random phase
    strobe(8'hE0); strobe(8'h75); strobe(8'hE0); strobe(8'hF0); strobe(8'h75);
    strobe(8'hE0); strobe(8'h12); strobe(8'hE0); strobe(8'h7C);
    strobe(8'hE1); strobe(8'h14); strobe(8'h77); strobe(8'hE1);
    strobe(8'hF0); strobe(8'h14); strobe(8'hF0); strobe(8'h77);
    idle(2);
    chk("ext_count", 32'(fifo_count[0]), 3);
    chk("ext_model0", 32'(mq[0][0]), {21'd0, 8'h75, 3'b100});
    chk("ext_model1", 32'(mq[0][1]), {21'd0, 8'h75, 3'b110});
    chk("ext_model2", 32'(mq[0][2]), {21'd0, 8'h7C, 3'b100});
    drain();

    // Held table full, re-make after break, then FIFO overflow.
    do_reset();
    strobe(8'h1C); strobe(8'h1B); strobe(8'h23); strobe(8'h2B); strobe(8'h34); strobe(8'h34);
    strobe(8'hF0); strobe(8'h1C); strobe(8'h1C);
    idle(2);
    chk("tbl_count0", 32'(fifo_count[0]), 8);
    chk("tbl_count1", 32'(fifo_count[1]), 8);
    chk("tbl_model5", 32'(mq[1][5]), {21'd0, 8'h34, 3'b000});
    chk("tbl_model7", 32'(mq[0][7]), {21'd0, 8'h1C, 3'b000});
    chk("pre_ovf", 32'(overflow[0]), 0);
    strobe(8'h3B);
    idle(2);
    chk("ovf_set", 32'(overflow[0]), 1);
    chk("ovf_count", 32'(fifo_count[0]), 8);
    clr_overflow = 1'b1;
    @(negedge clk);
    clr_overflow = 1'b0;
    chk("ovf_clr", 32'(overflow[0]), 0);
    byte_valid = 1'b1; byte_data = 8'h42;
    @(negedge clk);
    byte_valid = 1'b0; ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    idle(1);
    chk("pushpop_count", 32'(fifo_count[0]), 8);
    chk("pushpop_ovf", 32'(overflow[0]), 0);
    chk("pushpop_tail", 32'(mq[0][7]), {21'd0, 8'h42, 3'b000});
    drain();

    // Reset in the middle of an E0 F0 prefix.
    strobe(8'hE0); strobe(8'hF0);
    do_reset();
    strobe(8'h75);
    idle(2);
    chk("rstmid_count", 32'(fifo_count[0]), 1);
    chk("rstmid_head", {21'd0, ev_code[0], ev_ext[0], ev_break[0], ev_repeat[0]}, {21'd0, 8'h75, 3'b000});
    drain();

    // Randomised stream: first a mostly-stalled consumer, then a fast one.
    for (int i = 0; i < 4000; i++) begin
      if (i == 2000) do_reset();
      byte_valid   = ($urandom_range(99, 0) < 45);
      byte_data    = pool[$urandom_range(15, 0)];
      ev_ready     = ($urandom_range(99, 0) < ((i < 2000) ? 15 : 70));
      clr_overflow = ($urandom_range(99, 0) < 3);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    clr_overflow = 1'b0;
    ev_ready = 1'b0;
    idle(3);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_key_event.md
# ps2_key_event

Converts the raw PS/2 scan-byte stream from the keyboard receiver into discrete key events: make or break, extended (E0) flag, and typematic-repeat flag. Events are queued in a FIFO for the display/ASCII consumer. This block replaces ad-hoc "new key pressed" edge logic in the keyboard top level. It sits between the PS/2 byte receiver and the consumer, on the system clock.

## Interface
Parameters:
- FIFO_DEPTH, 8: event FIFO depth; power of 2, 2..64.
- HELD_KEYS, 4: size of the held-key table, 1..8.
- REPEAT_MODE, 0: 0 = typematic repeats dropped; 1 = repeats queued with ev_repeat=1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-high reset.
- byte_valid  in  1  one-cycle strobe; a received scan byte is present. Back-to-back strobes are legal.
- byte_data  in  8  scan byte, valid with byte_valid.
- ev_valid  out  1  FIFO head holds an event (first-word-fall-through).
- ev_ready  in  1  consumer accepts the head event when ev_valid && ev_ready.
- ev_code  out  8  make-code of the event key.
- ev_ext  out  1  key was E0-prefixed.
- ev_break  out  1  1 = release, 0 = press.
- ev_repeat  out  1  press of a key already held (REPEAT_MODE=1 only).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  number of queued events.
- overflow  out  1  sticky; set when an event is dropped because the FIFO is full.
- clr_overflow  in  1  synchronous clear of overflow; set wins if both occur in the same cycle.

## Operation
Parser FSM, advanced only on byte_valid:
- IDLE: F0→BRK; E0→EXT; E1→SKIP with skip counter=7; status bytes 00/AA/FA/FE/FF are discarded; any other byte emits make{ext=0}.
- EXT: F0→EXT_BRK; E0 stays in EXT; 12 (fake shift) is discarded and returns to IDLE; other bytes emit make{ext=1}→IDLE.
- BRK: byte emits break{ext=0}→IDLE.
- EXT_BRK: 12 is discarded; other bytes emit break{ext=1}. Both cases →IDLE.
- SKIP: decrement counter per byte; →IDLE after the 7th byte. The Pause sequence produces no event.

Held-key table: HELD_KEYS entries of {valid, ext, code}.
- Make, matching entry present: this is a repeat. Dropped if REPEAT_MODE=0; queued with ev_repeat=1 otherwise.
- Make, no match: queued with ev_repeat=0 and stored in the lowest free slot. If the table is full, the event is still queued with repeat=0 and is not stored.
- Break: clears the matching entry if one exists. The break is always queued, even with no match.

FIFO behaviour:
- Push and pop may happen in the same cycle, including when the FIFO is full (the pop frees the slot, no drop).
- A push to a full FIFO with no pop drops the new event and sets overflow.
- Pop on empty is ignored.
- Pointers wrap modulo FIFO_DEPTH; fifo_count spans 0..FIFO_DEPTH.

Reset (rst high, any time):
- FSM→IDLE, skip counter 0, table cleared, FIFO emptied.
- Outputs: ev_valid=0, ev_code=0, ev_ext=0, ev_break=0, ev_repeat=0, fifo_count=0, overflow=0.
- A partially received prefix sequence is discarded.

## Timing
- Byte accepted at edge k. Classification and table update register the event at edge k. FIFO write occurs at edge k+1.
- ev_valid rises after edge k+1 when the FIFO was empty. Latency is 2 cycles.
- Table lookup and update for byte k complete at edge k, so a back-to-back make/break of the same key resolves correctly.
- ev_* are registered FIFO-head values and are stable while ev_valid && !ev_ready.
- ev_valid deasserts the cycle after the last event is popped.

## Structure
- Package ps2_kbd_pkg:
  - scan constants: F0, E0, E1, 12, 00, AA, FA, FE, FF.
  - parser state enum: IDLE, EXT, BRK, EXT_BRK, SKIP.
  - key_event_t {code[7:0], ext, brk, rpt}, 11 bits.
- Sub-module key_event_fifo: synchronous FWFT FIFO, parametrised on FIFO_DEPTH, carrying key_event_t. It exposes full, empty and count.
- Parser and held-key table stay in ps2_key_event.

## Test plan
- Bytes 1C, F0, 1C → two events: {1C, ext0, brk0, rpt0} then {1C, ext0, brk1}. ev_valid first high 2 cycles after the 1C strobe.
- REPEAT_MODE=0, bytes 1C, 1C, 1C, F0, 1C → only a make and a break are queued. With REPEAT_MODE=1 → make, rpt, rpt, break.
- Bytes E0 75, E0 F0 75 → {75, ext1, brk0}, {75, ext1, brk1}. Bytes E0 12 E0 7C → single event {7C, ext1}. Pause sequence E1 14 77 E1 F0 14 F0 77 → no events.
- HELD_KEYS=4: makes 1C 1B 23 2B 34, then 34 again → 34 again is queued with rpt=0 (table full). Break 1C then make 1C → rpt=0.
- FIFO_DEPTH=8, ev_ready=0, 9 distinct makes → fifo_count=8, overflow=1, 9th event lost. Full FIFO with push and pop in the same cycle → no drop, count stays 8. clr_overflow → overflow=0.
- rst asserted mid-sequence after E0 F0, then byte 75 → make {75, ext0}. All outputs read 0 during reset.
